// File: rtl/clk_div_meas_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_meas_pkg
//  Description : Shared types and constants for the clock-period measurement
//                block: FSM state encoding, default counter width and the
//                saturation value of the default-width counter.
//  Revision    : 1.0  initial release
// ============================================================================
package clk_div_meas_pkg;

    // Default width of all counters and measurement outputs.
    localparam int DEF_W = 16;

    // Saturation value of a DEF_W-wide counter (2^W-1).
    localparam logic [DEF_W-1:0] CNT_MAX = {DEF_W{1'b1}};

    // Width of the consecutive-match counter; LOCK_CNT is limited to 1..15.
    localparam int MATCH_W = 4;

    // Measurement FSM: IDLE waits for a first reference rise, MEAS reports
    // a complete period on every subsequent rise.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MEAS = 1'b1
    } state_e;

endpackage : clk_div_meas_pkg
`default_nettype wire

// File: rtl/clk_div_measure_if.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_measure_if
//  Description : Bundle between the measured slow clock and its results.
//                slave  : the measuring block (takes CLK_IN, drives results)
//                master : the user (drives CLK_IN, observes results)
//  Signals     : CLK_IN     slow asynchronous clock under measurement
//                PERIOD     last period, CLK cycles rise-to-rise
//                HIGH_TIME  last high time, CLK cycles rise-to-fall
//                DIV_N      PERIOD>>1, equivalent even-divide factor
//                ODD        PERIOD[0], period is not an even divide
//                VALID      one-cycle pulse when the results update
//                LOCKED     period has been stable for LOCK_CNT matches
//                TIMEOUT    CLK_IN has stalled
//  Revision    : 1.0  initial release
// ============================================================================
interface clk_div_measure_if
    import clk_div_meas_pkg::*;
#(
    parameter int W = DEF_W
);

    logic         CLK_IN;
    logic [W-1:0] PERIOD;
    logic [W-1:0] HIGH_TIME;
    logic [W-1:0] DIV_N;
    logic         ODD;
    logic         VALID;
    logic         LOCKED;
    logic         TIMEOUT;

    modport master (
        output CLK_IN,
        input  PERIOD,
        input  HIGH_TIME,
        input  DIV_N,
        input  ODD,
        input  VALID,
        input  LOCKED,
        input  TIMEOUT
    );

    modport slave (
        input  CLK_IN,
        output PERIOD,
        output HIGH_TIME,
        output DIV_N,
        output ODD,
        output VALID,
        output LOCKED,
        output TIMEOUT
    );

endinterface : clk_div_measure_if
`default_nettype wire

// File: rtl/clk_div_meas_sync.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_meas_sync
//  Description : Two-flop synchroniser for a slow asynchronous input followed
//                by an edge-detect flop. Produces single-cycle rise/fall
//                strobes a fixed 3 CLK edges after the input edge.
//  Ports       : CLK     system clock
//                RST_N   asynchronous active-low reset
//                async_i asynchronous slow input
//                rise_o  one-cycle strobe on a synchronised rising edge
//                fall_o  one-cycle strobe on a synchronised falling edge
//  Revision    : 1.0  initial release
// ============================================================================
module clk_div_meas_sync (
    input  logic CLK,
    input  logic RST_N,
    input  logic async_i,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q;   // metastability capture
    logic s2_q;   // synchronised level
    logic s3_q;   // previous synchronised level, for edge detection

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= async_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise_o =  s2_q & ~s3_q;
    assign fall_o = ~s2_q &  s3_q;

endmodule : clk_div_meas_sync
`default_nettype wire

// File: rtl/clk_div_measure.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_measure
//  Description : Measures a slow asynchronous clock in CLK cycles: period,
//                high time, equivalent even-divide factor and odd flag.
//                Tracks period stability (LOCKED) and input stalls (TIMEOUT).
//  Parameters  : W           width of counters and results
//                TIMEOUT_CYC cycles without a rise before TIMEOUT (4..2^W-1)
//                LOCK_CNT    consecutive equal periods for LOCKED (1..15)
//  Ports       : CLK         system clock, rising edge
//                RST_N       asynchronous active-low reset
//                bus         clk_div_measure_if.slave (CLK_IN in, results out)
//  Revision    : 1.0  initial release
// ============================================================================
module clk_div_measure
    import clk_div_meas_pkg::*;
#(
    parameter int          W           = DEF_W,
    parameter int unsigned TIMEOUT_CYC = 32'h0000_FFFF,
    parameter int          LOCK_CNT    = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    clk_div_measure_if.slave  bus
);

    localparam logic [W-1:0]       L_CNT_MAX = {W{1'b1}};
    localparam logic [W-1:0]       L_TIMEOUT = W'(TIMEOUT_CYC);
    localparam logic [W-1:0]       L_ONE     = W'(1);
    localparam logic [MATCH_W-1:0] L_LOCK    = MATCH_W'(LOCK_CNT);

    // ------------------------------------------------------------------
    // Input synchronisation and edge detection
    // ------------------------------------------------------------------
    logic w_rise;
    logic w_fall;

    clk_div_meas_sync u_sync (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .async_i (bus.CLK_IN),
        .rise_o  (w_rise),
        .fall_o  (w_fall)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e               state_q;
    logic [W-1:0]         cnt_q;
    logic [W-1:0]         cnt_d;
    logic [W-1:0]         hcap_q;
    logic [MATCH_W-1:0]   match_q;
    logic [MATCH_W-1:0]   match_d;
    logic                 have_meas_q;   // a PERIOD has been reported since reset

    logic [W-1:0]         period_q;
    logic [W-1:0]         high_q;
    logic [W-1:0]         div_q;
    logic                 odd_q;
    logic                 valid_q;
    logic                 locked_q;
    logic                 timeout_q;

    logic                 w_timeout_hit;
    logic                 w_period_match;

    // The counter restarts at 1 on a rise because the rise cycle itself is
    // the first cycle of the new period; the fixed synchroniser latency is
    // identical for both edges and so drops out of every difference.
    always_comb begin
        cnt_d = (cnt_q == L_CNT_MAX) ? cnt_q : (cnt_q + L_ONE);
        if (w_rise) begin
            cnt_d = L_ONE;
        end
    end

    // Timeout is judged on the value the counter is about to take, so the
    // flag rises on the very edge where cnt reaches TIMEOUT_CYC. A rise in
    // the same cycle forces cnt_d to 1, which is how rise_det wins.
    assign w_timeout_hit = (cnt_d == L_TIMEOUT);

    assign w_period_match = have_meas_q && (cnt_q == period_q);

    always_comb begin
        match_d = '0;
        if (w_period_match) begin
            match_d = (match_q >= L_LOCK) ? L_LOCK : (match_q + MATCH_W'(1));
        end
    end

    // ------------------------------------------------------------------
    // Measurement FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            hcap_q      <= '0;
            match_q     <= '0;
            have_meas_q <= 1'b0;
            period_q    <= '0;
            high_q      <= '0;
            div_q       <= '0;
            odd_q       <= 1'b0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            cnt_q   <= cnt_d;

            // Rise and fall strobes are mutually exclusive.
            if (w_fall) begin
                hcap_q <= cnt_q;
            end

            if (w_rise) begin
                hcap_q    <= '0;
                timeout_q <= 1'b0;
                state_q   <= ST_MEAS;
                case (state_q)
                    ST_MEAS: begin
                        period_q    <= cnt_q;
                        high_q      <= hcap_q;
                        div_q       <= cnt_q >> 1;
                        odd_q       <= cnt_q[0];
                        valid_q     <= 1'b1;
                        match_q     <= match_d;
                        locked_q    <= (match_d == L_LOCK);
                        have_meas_q <= 1'b1;
                    end
                    default: begin
                        // First rise only sets the reference point.
                    end
                endcase
            end else if (w_timeout_hit) begin
                timeout_q <= 1'b1;
                locked_q  <= 1'b0;
                match_q   <= '0;
                state_q   <= ST_IDLE;
            end
        end
    end

    assign bus.PERIOD    = period_q;
    assign bus.HIGH_TIME = high_q;
    assign bus.DIV_N     = div_q;
    assign bus.ODD       = odd_q;
    assign bus.VALID     = valid_q;
    assign bus.LOCKED    = locked_q;
    assign bus.TIMEOUT   = timeout_q;

endmodule : clk_div_measure
`default_nettype wire

// File: tb/tb_clk_div_measure.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_clk_div_measure
//  Description : Directed self-checking bench for clk_div_measure: table of
//                CLK_IN periods with hand-computed results, plus stall,
//                reset-mid-measurement and jittered-edge sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_clk_div_measure;

    logic CLK;
    logic RST_N;

    clk_div_measure_if #(.W(16)) bus ();

    clk_div_measure #(
        .W           (16),
        .TIMEOUT_CYC (100),
        .LOCK_CNT    (4)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int rt     = 0;     // cycle index of the most recent driven rise
    int nval   = 0;     // VALID pulses seen since last cleared
    int lat_period, lat_high, lat_div, lat_odd, lat_locked;

    bit jit_en   = 1'b0;
    int jit_nval = 0;

    typedef struct {
        int hi;
        int lo;
        bit exp_valid;
        int exp_period;
        int exp_high;
        int exp_div;
        bit exp_odd;
        bit exp_locked;
    } vec_t;

    vec_t vecs [23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One CLK cycle; samples 1ns after the rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
        if (bus.VALID === 1'b1) begin
            nval++;
            lat_period = int'(bus.PERIOD);
            lat_high   = int'(bus.HIGH_TIME);
            lat_div    = int'(bus.DIV_N);
            lat_odd    = int'(bus.ODD);
            lat_locked = int'(bus.LOCKED);
        end
    endtask

    // Drive one CLK_IN period: high for hi cycles, then low for lo cycles.
    task automatic apply_period(input int hi, input int lo);
        nval = 0;
        bus.CLK_IN = 1'b1;
        rt = cyc;
        repeat (hi) tick();
        bus.CLK_IN = 1'b0;
        repeat (lo) tick();
    endtask

    function automatic vec_t mk(input int hi, input int lo, input bit v, input int p,
                                input int h, input int d, input bit o, input bit l);
        vec_t r;
        r.hi = hi; r.lo = lo; r.exp_valid = v; r.exp_period = p;
        r.exp_high = h; r.exp_div = d; r.exp_odd = o; r.exp_locked = l;
        return r;
    endfunction

    // Jittered phase: every VALID after the first must report 39..41.
    always @(negedge CLK) begin
        if (jit_en && bus.VALID === 1'b1) begin
            if (jit_nval > 0) begin
                checks++;
                if ($isunknown(bus.PERIOD) || bus.PERIOD < 16'd39 || bus.PERIOD > 16'd41) begin
                    errors++;
                    $display("FAIL jitter PERIOD: got %0d required 39..41", bus.PERIOD);
                end
            end
            jit_nval++;
        end
    end

    initial begin
        // Each entry's expectations describe the VALID produced by that
        // entry's own rise, i.e. the period of the previous entry.
        vecs[0]  = mk(10, 10, 0,  0,  0,  0, 0, 0);  // first rise: reference only
        vecs[1]  = mk(10, 10, 1, 20, 10, 10, 0, 0);
        vecs[2]  = mk(10, 10, 1, 20, 10, 10, 0, 0);  // match 1
        vecs[3]  = mk(10, 10, 1, 20, 10, 10, 0, 0);  // match 2
        vecs[4]  = mk(10, 10, 1, 20, 10, 10, 0, 0);  // match 3
        vecs[5]  = mk(10, 10, 1, 20, 10, 10, 0, 1);  // 5th VALID, match 4
        vecs[6]  = mk(10, 10, 1, 20, 10, 10, 0, 1);
        vecs[7]  = mk( 6,  6, 1, 20, 10, 10, 0, 1);  // frequency step starts
        vecs[8]  = mk( 6,  6, 1, 12,  6,  6, 0, 0);  // first new period breaks lock
        vecs[9]  = mk( 6,  6, 1, 12,  6,  6, 0, 0);
        vecs[10] = mk( 6,  6, 1, 12,  6,  6, 0, 0);
        vecs[11] = mk( 6,  6, 1, 12,  6,  6, 0, 0);
        vecs[12] = mk( 6,  6, 1, 12,  6,  6, 0, 1);  // relocked 4 VALIDs later
        vecs[13] = mk( 3,  4, 1, 12,  6,  6, 0, 1);
        vecs[14] = mk( 3,  4, 1,  7,  3,  3, 1, 0);  // odd / asymmetric
        vecs[15] = mk( 3,  4, 1,  7,  3,  3, 1, 0);
        vecs[16] = mk(10, 10, 1,  7,  3,  3, 1, 0);
        vecs[17] = mk(10, 10, 1, 20, 10, 10, 0, 0);
        vecs[18] = mk(10, 10, 1, 20, 10, 10, 0, 0);
        vecs[19] = mk(10, 10, 1, 20, 10, 10, 0, 0);
        vecs[20] = mk(10, 10, 1, 20, 10, 10, 0, 0);
        vecs[21] = mk(10, 10, 1, 20, 10, 10, 0, 1);
        vecs[22] = mk(10, 10, 1, 20, 10, 10, 0, 1);

        // ---------------- reset ----------------
        RST_N = 1'b0;
        bus.CLK_IN = 1'b0;
        repeat (3) tick();
        chk("reset PERIOD",    32'(bus.PERIOD),    0);
        chk("reset HIGH_TIME", 32'(bus.HIGH_TIME), 0);
        chk("reset VALID",     32'(bus.VALID),     0);
        chk("reset LOCKED",    32'(bus.LOCKED),    0);
        chk("reset TIMEOUT",   32'(bus.TIMEOUT),   0);
        RST_N = 1'b1;
        repeat (5) tick();
        chk("idle VALID", 32'(bus.VALID), 0);

        // ---------------- table ----------------
        for (int i = 0; i < 23; i++) begin
            apply_period(vecs[i].hi, vecs[i].lo);
            chk($sformatf("v%0d VALID count", i), 32'(nval), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                chk($sformatf("v%0d PERIOD", i),    32'(lat_period), 32'(vecs[i].exp_period));
                chk($sformatf("v%0d HIGH_TIME", i), 32'(lat_high),   32'(vecs[i].exp_high));
                chk($sformatf("v%0d DIV_N", i),     32'(lat_div),    32'(vecs[i].exp_div));
                chk($sformatf("v%0d ODD", i),       32'(lat_odd),    32'(vecs[i].exp_odd));
                chk($sformatf("v%0d LOCKED", i),    32'(lat_locked), 32'(vecs[i].exp_locked));
            end
            chk($sformatf("v%0d TIMEOUT", i), 32'(bus.TIMEOUT), 0);
        end

        // ---------------- stall ----------------
        // Last rise at cycle rt: detected 3 edges later (cnt=1), cnt reaches
        // 100 on edge rt+102.
        nval = 0;
        while (cyc < rt + 101) tick();
        chk("stall pre TIMEOUT", 32'(bus.TIMEOUT), 0);
        chk("stall pre LOCKED",  32'(bus.LOCKED),  1);
        tick();
        chk("stall TIMEOUT",     32'(bus.TIMEOUT),   1);
        chk("stall LOCKED",      32'(bus.LOCKED),    0);
        chk("stall PERIOD hold", 32'(bus.PERIOD),    20);
        chk("stall HIGH hold",   32'(bus.HIGH_TIME), 10);
        repeat (20) tick();
        chk("stall TIMEOUT held", 32'(bus.TIMEOUT), 1);
        chk("stall no VALID",     32'(nval),        0);

        apply_period(10, 10);
        chk("restart1 VALID count", 32'(nval),        0);
        chk("restart1 TIMEOUT",     32'(bus.TIMEOUT), 0);
        chk("restart1 PERIOD hold", 32'(bus.PERIOD),  20);
        apply_period(10, 10);
        chk("restart2 VALID count", 32'(nval),       1);
        chk("restart2 PERIOD",      32'(lat_period), 20);
        chk("restart2 LOCKED",      32'(lat_locked), 0);

        // ---------------- reset mid-measurement ----------------
        nval = 0;
        bus.CLK_IN = 1'b1;
        repeat (10) tick();
        bus.CLK_IN = 1'b0;
        repeat (4) tick();
        chk("premid PERIOD", 32'(bus.PERIOD), 20);
        RST_N = 1'b0;
        #1;
        chk("midrst PERIOD",    32'(bus.PERIOD),    0);
        chk("midrst HIGH_TIME", 32'(bus.HIGH_TIME), 0);
        chk("midrst DIV_N",     32'(bus.DIV_N),     0);
        chk("midrst LOCKED",    32'(bus.LOCKED),    0);
        tick();
        RST_N = 1'b1;
        repeat (6) tick();
        apply_period(10, 10);
        chk("postrst1 VALID count", 32'(nval), 0);
        apply_period(10, 10);
        chk("postrst2 VALID count", 32'(nval),       1);
        chk("postrst2 PERIOD",      32'(lat_period), 20);
        chk("postrst2 HIGH_TIME",   32'(lat_high),   10);
        chk("postrst2 LOCKED",      32'(lat_locked), 0);

        // ---------------- jittered edges, period 40 ----------------
        begin
            longint t0;
            longint t;
            int off;
            t0 = ($time / 10) * 10 + 200;
            jit_en = 1'b1;
            for (int k = 0; k < 12; k++) begin
                off = int'($urandom_range(0, 8)) - 4;
                t = t0 + 400 * k + off;
                #(t - $time) bus.CLK_IN = 1'b1;
                off = int'($urandom_range(0, 8)) - 4;
                t = t0 + 400 * k + 200 + off;
                #(t - $time) bus.CLK_IN = 1'b0;
            end
            repeat (10) @(posedge CLK);
            #1;
            jit_en = 1'b0;
        end
        chk("jitter VALID count", 32'(jit_nval), 12);
        chk("jitter no TIMEOUT",  32'(bus.TIMEOUT), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_clk_div_measure
`default_nettype wire
